// File: rtl/adder_stage_pkg.sv
// adder_stage_pkg: shared types and constants for the adder stage wrapper.
//   state_t         : controller FSM state encoding (IDLE, SETTLE)
//   W_DEF/SUM_W_DEF : default operand / sum widths of the prefix adder
//   SETTLE_CYC_MAX  : largest supported settle time; sizes the settle counter
package adder_stage_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int unsigned W_DEF          = 6;
    localparam int unsigned SUM_W_DEF      = W_DEF + 1;
    localparam int unsigned SETTLE_CYC_MAX = 15;
    localparam int unsigned SETTLE_W       = $clog2(SETTLE_CYC_MAX + 1);

endpackage : adder_stage_pkg

// File: rtl/adder_stage_fifo.sv
// adder_stage_fifo: synchronous DEPTH-entry result FIFO (DEPTH a power of two).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (clears pointers/count)
//   push, push_data   : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   head              : entry at the read pointer, 0 when empty
//   count             : number of stored entries, 0..DEPTH
//   full, empty       : occupancy flags
module adder_stage_fifo #(
    parameter  int unsigned DW    = 7,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;

    // Empty FIFO presents zero rather than stale storage.
    assign head = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : adder_stage_fifo

// File: rtl/adder_stage_ctrl.sv
// adder_stage_ctrl: sequential wrapper around the external combinational
// prefix adder. Operands are accepted over in_valid/in_ready, registered onto
// add_x/add_y, and after SETTLE_CYC cycles add_s is captured into a result
// FIFO drained over out_valid/out_ready.
// Optional build macro: ADDER_STAGE_CHECK_EN enables a behavioural sum checker
// driving the sticky err flag; when undefined err is tied low.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_x/in_y operands
//   add_x/add_y         : registered operands to the adder
//   add_s               : adder sum (sampled only on the capture edge)
//   out_valid/out_ready : result handshake, out_sum is the FIFO head
//   done_cnt            : popped-result counter, wraps
//   err                 : sticky sum-mismatch flag
module adder_stage_ctrl
    import adder_stage_pkg::*;
#(
    parameter int unsigned W          = W_DEF,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    output logic [W-1:0]     add_x,
    output logic [W-1:0]     add_y,
    input  logic [W:0]       add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err
);

    localparam int unsigned SUM_W = W + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settle_done;
    logic                slot_free;
    logic                load_c;
    logic                capture_c;
    logic                pop_c;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign settle_done = (settle_cnt == '0);
    assign slot_free   = (fifo_count < CW'(DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid && slot_free) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake ready, operand load and sum capture strobes.
    always_comb begin
        in_ready  = 1'b0;
        load_c    = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready = slot_free;
                load_c   = in_valid && slot_free;
            end
            SETTLE: begin
                capture_c = settle_done;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand registers hold between operations; settle counter times capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_x      <= '0;
            add_y      <= '0;
            settle_cnt <= '0;
        end else if (load_c) begin
            add_x      <= in_x;
            add_y      <= in_y;
            settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
        end else if ((state == SETTLE) && !settle_done) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
    end

    // A slot is reserved at accept time, so a capture never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (rst_n && capture_c) begin
            assert (!fifo_full)
            else $error("capture into full result FIFO");
        end
    end

    assign pop_c     = !fifo_empty && out_ready;
    assign out_valid = !fifo_empty;

    adder_stage_fifo #(
        .DW    (SUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture_c),
        .push_data (add_s),
        .pop       (pop_c),
        .head      (out_sum),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Completed-result counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (pop_c) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

`ifdef ADDER_STAGE_CHECK_EN
    logic [SUM_W-1:0] exp_sum;

    assign exp_sum = SUM_W'(add_x) + SUM_W'(add_y);

    // Sticky mismatch flag; the captured value is still the adder's output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (capture_c && (add_s != exp_sum)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule : adder_stage_ctrl

// File: tb/tb_adder_stage_ctrl.sv
// tb_adder_stage_ctrl: directed self-checking bench for adder_stage_ctrl.
// u_dut uses default parameters; u_dut3 uses SETTLE_CYC=3, CNT_W=2.
module tb_adder_stage_ctrl;

`ifdef ADDER_STAGE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    // Instance 1: defaults
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, err, corrupt;
    logic [5:0]  in_x, in_y, add_x, add_y;
    logic [6:0]  add_s, out_sum;
    logic [15:0] done_cnt;

    // Instance 2: SETTLE_CYC=3, CNT_W=2
    logic        rst3_n, in_valid3, in_ready3, out_valid3, out_ready3, err3;
    logic [5:0]  in_x3, in_y3, add_x3, add_y3;
    logic [6:0]  add_s3, out_sum3;
    logic [1:0]  done_cnt3;

    // Adder models; corrupt forces a wrong sum for instance 1.
    assign add_s  = corrupt ? 7'd0 : (7'(add_x) + 7'(add_y));
    assign add_s3 = 7'(add_x3) + 7'(add_y3);

    adder_stage_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .done_cnt  (done_cnt),
        .err       (err)
    );

    adder_stage_ctrl #(
        .SETTLE_CYC (3),
        .CNT_W      (2)
    ) u_dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_x      (in_x3),
        .in_y      (in_y3),
        .add_x     (add_x3),
        .add_y     (add_y3),
        .add_s     (add_s3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_sum   (out_sum3),
        .done_cnt  (done_cnt3),
        .err       (err3)
    );

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        checks++; if (out_sum !== 7'd0) begin errors++; $display("FAIL reset_out_sum: got %0d exp 0", out_sum); end
        checks++; if (add_x !== 6'd0 || add_y !== 6'd0) begin errors++; $display("FAIL reset_operands: got x=%0d y=%0d exp 0 0", add_x, add_y); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d exp 0", done_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        checks++; if (out_valid3 !== 1'b0 || done_cnt3 !== 2'd0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got v=%0b cnt=%0d err=%0b exp 0 0 0", out_valid3, done_cnt3, err3); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %0b exp 1", in_ready); end
        in_x = 6'd63; in_y = 6'd63; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_settle: got %0b exp 0", in_ready); end
        checks++; if (add_x !== 6'd63 || add_y !== 6'd63) begin errors++; $display("FAIL basic_load: got x=%0d y=%0d exp 63 63", add_x, add_y); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 7'd126) begin errors++; $display("FAIL basic_sum: got v=%0b sum=%0d exp 1 126", out_valid, out_sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %0b exp 1", in_ready); end
        @(negedge clk);
        exp_done = exp_done + 1;
        checks++; if (out_valid !== 1'b0 || done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL basic_pop: got v=%0b cnt=%0d exp 0 %0d", out_valid, done_cnt, exp_done); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_x = 6'd0; in_y = 6'd0; in_valid = 1'b1;
        @(negedge clk);
        in_x = 6'd1; in_y = 6'd62;
        checks++; if (in_ready !== 1'b0 || add_x !== 6'd0) begin errors++; $display("FAIL b2b_settle1: got rdy=%0b x=%0d exp 0 0", in_ready, add_x); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_sum !== 7'd0) begin errors++; $display("FAIL b2b_first: got rdy=%0b v=%0b sum=%0d exp 1 1 0", in_ready, out_valid, out_sum); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || add_x !== 6'd1 || add_y !== 6'd62) begin errors++; $display("FAIL b2b_settle2: got rdy=%0b x=%0d y=%0d exp 0 1 62", in_ready, add_x, add_y); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_sum !== 7'd0) begin errors++; $display("FAIL b2b_full: got rdy=%0b head=%0d exp 0 0", in_ready, out_sum); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 7'd63) begin errors++; $display("FAIL b2b_second: got v=%0b sum=%0d exp 1 63", out_valid, out_sum); end
        @(negedge clk);
        out_ready = 1'b0;
        exp_done = exp_done + 2;
        checks++; if (out_valid !== 1'b0 || done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL b2b_drain: got v=%0b cnt=%0d exp 0 %0d", out_valid, done_cnt, exp_done); end
    endtask

    task automatic test_fifo_full();
        out_ready = 1'b0;
        in_x = 6'd5; in_y = 6'd3; in_valid = 1'b1;
        @(negedge clk);
        in_x = 6'd10; in_y = 6'd20;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_sum !== 7'd8) begin errors++; $display("FAIL full_op1: got rdy=%0b head=%0d exp 1 8", in_ready, out_sum); end
        @(negedge clk);
        in_x = 6'd33; in_y = 6'd31;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_sum !== 7'd8) begin errors++; $display("FAIL full_two: got rdy=%0b head=%0d exp 0 8", in_ready, out_sum); end
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || add_x !== 6'd10) begin errors++; $display("FAIL full_stall: got rdy=%0b x=%0d exp 0 10", in_ready, add_x); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_sum !== 7'd30) begin errors++; $display("FAIL full_pop1: got rdy=%0b head=%0d exp 1 30", in_ready, out_sum); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || add_x !== 6'd33 || add_y !== 6'd31) begin errors++; $display("FAIL full_op3_load: got rdy=%0b x=%0d y=%0d exp 0 33 31", in_ready, add_x, add_y); end
        @(negedge clk);
        checks++; if (out_sum !== 7'd30) begin errors++; $display("FAIL full_order: got head=%0d exp 30", out_sum); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 7'd64) begin errors++; $display("FAIL full_op3: got v=%0b head=%0d exp 1 64", out_valid, out_sum); end
        @(negedge clk);
        out_ready = 1'b0;
        exp_done = exp_done + 3;
        checks++; if (out_valid !== 1'b0 || done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL full_drain: got v=%0b cnt=%0d exp 0 %0d", out_valid, done_cnt, exp_done); end
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        corrupt = 1'b1;
        in_x = 6'd12; in_y = 6'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 7'd0) begin errors++; $display("FAIL err_capture: got v=%0b sum=%0d exp 1 0", out_valid, out_sum); end
        checks++; if (err !== ERR_EXP) begin errors++; $display("FAIL err_set: got %0b exp %0b", err, ERR_EXP); end
        corrupt = 1'b0;
        in_x = 6'd1; in_y = 6'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_pop: got v=%0b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_sum !== 7'd2 || err !== ERR_EXP) begin errors++; $display("FAIL err_sticky: got sum=%0d err=%0b exp 2 %0b", out_sum, err, ERR_EXP); end
        @(negedge clk);
        out_ready = 1'b0;
        exp_done = exp_done + 2;
        checks++; if (done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL err_done_cnt: got %0d exp %0d", done_cnt, exp_done); end
    endtask

    task automatic test_reset_mid_settle();
        out_ready3 = 1'b1;
        in_x3 = 6'd9; in_y3 = 6'd4; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        checks++; if (in_ready3 !== 1'b0 || add_x3 !== 6'd9) begin errors++; $display("FAIL rst_mid_load: got rdy=%0b x=%0d exp 0 9", in_ready3, add_x3); end
        @(negedge clk);
        rst3_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid3 !== 1'b0 || out_sum3 !== 7'd0) begin errors++; $display("FAIL rst_mid_fifo: got v=%0b sum=%0d exp 0 0", out_valid3, out_sum3); end
        checks++; if (add_x3 !== 6'd0 || add_y3 !== 6'd0) begin errors++; $display("FAIL rst_mid_operands: got x=%0d y=%0d exp 0 0", add_x3, add_y3); end
        checks++; if (in_ready3 !== 1'b1 || done_cnt3 !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got rdy=%0b cnt=%0d exp 1 0", in_ready3, done_cnt3); end
        rst3_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid3 !== 1'b0 || done_cnt3 !== 2'd0) begin errors++; $display("FAIL rst_mid_no_push: got v=%0b cnt=%0d exp 0 0", out_valid3, done_cnt3); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_seq [5];
        logic [5:0] x;
        logic [5:0] y;
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        out_ready3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 6'(i * 5 + 1);
            y = 6'(2 * i + 3);
            in_x3 = x; in_y3 = y; in_valid3 = 1'b1;
            @(negedge clk);
            in_valid3 = 1'b0;
            checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL wrap_settle_ready[%0d]: got %0b exp 0", i, in_ready3); end
            repeat (2) @(negedge clk);
            checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL wrap_latency[%0d]: got v=%0b exp 0", i, out_valid3); end
            @(negedge clk);
            checks++; if (out_valid3 !== 1'b1 || out_sum3 !== (7'(x) + 7'(y))) begin errors++; $display("FAIL wrap_sum[%0d]: got v=%0b sum=%0d exp 1 %0d", i, out_valid3, out_sum3, 7'(x) + 7'(y)); end
            @(negedge clk);
            checks++; if (done_cnt3 !== exp_seq[i]) begin errors++; $display("FAIL wrap_done_cnt[%0d]: got %0d exp %0d", i, done_cnt3, exp_seq[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0; corrupt = 1'b0;
        in_valid3 = 1'b0; in_x3 = '0; in_y3 = '0; out_ready3 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_back_to_back();
        test_fifo_full();
        test_err();
        test_reset_mid_settle();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_adder_stage_ctrl
